// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, step encoding and strobe bundle for the hardwired
// control sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Encoding doubles as the debug step output.
  typedef enum logic [3:0] {
    STEP_T0     = 4'd0,
    STEP_T1     = 4'd1,
    STEP_T2     = 4'd2,
    STEP_T3     = 4'd3,
    STEP_T4     = 4'd4,
    STEP_T5     = 4'd5,
    STEP_T6     = 4'd6,
    STEP_T7     = 4'd7,
    STEP_RESET  = 4'd8,
    STEP_HALTED = 4'd9
  } step_e;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       c_out;
    logic       ba_out;
    logic       mar_en;
    logic       pc_en;
    logic       mdr_en;
    logic       ir_en;
    logic       y_en;
    logic       z_en;
    logic       inc_pc;
    logic       read;
    logic       ram_we;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       rins_link;
    logic [4:0] alu_op;
  } strobes_t;

  function automatic logic is_alu_reg(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-unit boundary: opcode/ready inputs from the datapath and every
// control strobe going back to it.
interface control_sequencer_if #(
  parameter int NUM_REGS = 16
);
  logic [4:0]          ir_opcode;
  logic                mem_ready;

  logic                PC_out;
  logic                ZLow_out;
  logic                MDR_out;
  logic                C_out;
  logic                BA_out;
  logic                MAR_enable;
  logic                PC_enable;
  logic                MDR_enable;
  logic                IR_enable;
  logic                Y_enable;
  logic                Z_enable;
  logic                IncPC;
  logic                Read;
  logic                RAM_write_enable;
  logic                Gra;
  logic                Grb;
  logic                Grc;
  logic                R_in;
  logic                R_out;
  logic [NUM_REGS-1:0] Rins;
  logic [4:0]          alu_op;
  logic [3:0]          step;
  logic                run;

  modport master (
    input  ir_opcode, mem_ready,
    output PC_out, ZLow_out, MDR_out, C_out, BA_out,
    output MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, Z_enable,
    output IncPC, Read, RAM_write_enable,
    output Gra, Grb, Grc, R_in, R_out, Rins, alu_op, step, run
  );

  modport slave (
    output ir_opcode, mem_ready,
    input  PC_out, ZLow_out, MDR_out, C_out, BA_out,
    input  MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, Z_enable,
    input  IncPC, Read, RAM_write_enable,
    input  Gra, Grb, Grc, R_in, R_out, Rins, alu_op, step, run
  );
endinterface

// File: rtl/ctrl_decode.sv
// Pure Moore decode of (step, captured opcode) into the datapath strobe bundle.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  step_e      i_state,
  input  logic [4:0] i_op,
  output strobes_t   o_strb
);

  logic w_ld;
  logic w_st;
  logic w_mem;
  logic w_alu;
  logic w_addi;

  assign w_ld   = (i_op == OP_LD);
  assign w_st   = (i_op == OP_ST);
  assign w_mem  = is_mem_op(i_op);
  assign w_alu  = is_alu_reg(i_op);
  assign w_addi = (i_op == OP_ADDI);

  always_comb begin
    // NOTE: every output gets a value before the case so no path can infer a latch.
    o_strb        = '0;
    o_strb.alu_op = OP_ADD;
    case (i_state)
      STEP_T0: begin
        o_strb.pc_out = 1'b1;
        o_strb.mar_en = 1'b1;
        o_strb.inc_pc = 1'b1;
        o_strb.z_en   = 1'b1;
      end
      STEP_T1: begin
        o_strb.zlow_out = 1'b1;
        o_strb.pc_en    = 1'b1;
        o_strb.read     = 1'b1;
        o_strb.mdr_en   = 1'b1;
      end
      STEP_T2: begin
        o_strb.mdr_out = 1'b1;
        o_strb.ir_en   = 1'b1;
      end
      STEP_T3: begin
        if (i_op == OP_JAL) begin
          o_strb.pc_out    = 1'b1;
          o_strb.rins_link = 1'b1;
        end else if (i_op == OP_JR) begin
          o_strb.gra   = 1'b1;
          o_strb.r_out = 1'b1;
          o_strb.pc_en = 1'b1;
        end else if (w_mem) begin
          o_strb.grb    = 1'b1;
          o_strb.ba_out = 1'b1;
          o_strb.y_en   = 1'b1;
        end else if (w_alu || w_addi) begin
          o_strb.grb   = 1'b1;
          o_strb.r_out = 1'b1;
          o_strb.y_en  = 1'b1;
        end
      end
      STEP_T4: begin
        if (i_op == OP_JAL) begin
          o_strb.gra   = 1'b1;
          o_strb.r_out = 1'b1;
          o_strb.pc_en = 1'b1;
        end else if (w_mem || w_addi) begin
          o_strb.c_out = 1'b1;
          o_strb.z_en  = 1'b1;
        end else if (w_alu) begin
          o_strb.grc    = 1'b1;
          o_strb.r_out  = 1'b1;
          o_strb.z_en   = 1'b1;
          o_strb.alu_op = i_op;
        end
      end
      STEP_T5: begin
        if (w_mem) begin
          o_strb.zlow_out = 1'b1;
          o_strb.mar_en   = 1'b1;
        end else if (w_alu || w_addi) begin
          o_strb.zlow_out = 1'b1;
          o_strb.gra      = 1'b1;
          o_strb.r_in     = 1'b1;
        end
      end
      STEP_T6: begin
        if (w_ld) begin
          o_strb.read   = 1'b1;
          o_strb.mdr_en = 1'b1;
        end else if (w_st) begin
          o_strb.gra    = 1'b1;
          o_strb.r_out  = 1'b1;
          o_strb.mdr_en = 1'b1;
        end
      end
      STEP_T7: begin
        if (w_ld) begin
          o_strb.mdr_out = 1'b1;
          o_strb.gra     = 1'b1;
          o_strb.r_in    = 1'b1;
        end else if (w_st) begin
          o_strb.ram_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: steps T0..T7 per instruction, stalls
// memory reads on mem_ready and parks in HALTED until clr.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int LINK_REG    = 15,
  parameter int NUM_REGS    = 16,
  parameter int MEM_WAIT_EN = 1
) (
  input logic                 Clock,
  input logic                 clr,
  control_sequencer_if.master ctrl
);

  step_e               r_state;
  step_e               w_next;
  logic [4:0]          r_op;
  logic                w_wait;
  strobes_t            w_strb;
  logic [NUM_REGS-1:0] w_rins;

  assign w_wait = (MEM_WAIT_EN != 0) && !ctrl.mem_ready;

  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      r_state <= STEP_RESET;
      r_op    <= OP_NOP;
    end else begin
      // NOTE: non-blocking so r_op captures against the old r_state on this edge.
      r_state <= w_next;
      if (r_state == STEP_T2) begin
        r_op <= ctrl.ir_opcode;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      STEP_RESET: w_next = STEP_T0;
      STEP_T0:    w_next = STEP_T1;
      STEP_T1:    w_next = w_wait ? STEP_T1 : STEP_T2;
      STEP_T2:    w_next = STEP_T3;
      STEP_T3: begin
        if (r_op == OP_HALT) begin
          w_next = STEP_HALTED;
        end else if ((r_op == OP_JAL) || (r_op == OP_ADDI) ||
                     is_mem_op(r_op) || is_alu_reg(r_op)) begin
          w_next = STEP_T4;
        end else begin
          w_next = STEP_T0;
        end
      end
      STEP_T4: begin
        if (is_mem_op(r_op) || is_alu_reg(r_op) || (r_op == OP_ADDI)) begin
          w_next = STEP_T5;
        end else begin
          w_next = STEP_T0;
        end
      end
      STEP_T5:    w_next = is_mem_op(r_op) ? STEP_T6 : STEP_T0;
      STEP_T6: begin
        if (!is_mem_op(r_op)) begin
          w_next = STEP_T0;
        end else if ((r_op == OP_LD) && w_wait) begin
          w_next = STEP_T6;
        end else begin
          w_next = STEP_T7;
        end
      end
      STEP_T7:     w_next = STEP_T0;
      STEP_HALTED: w_next = STEP_HALTED;
      default:     w_next = STEP_RESET;
    endcase
  end

  ctrl_decode u_decode (
    .i_state (r_state),
    .i_op    (r_op),
    .o_strb  (w_strb)
  );

  always_comb begin
    w_rins           = '0;
    w_rins[LINK_REG] = w_strb.rins_link;
  end

  assign ctrl.PC_out           = w_strb.pc_out;
  assign ctrl.ZLow_out         = w_strb.zlow_out;
  assign ctrl.MDR_out          = w_strb.mdr_out;
  assign ctrl.C_out            = w_strb.c_out;
  assign ctrl.BA_out           = w_strb.ba_out;
  assign ctrl.MAR_enable       = w_strb.mar_en;
  assign ctrl.PC_enable        = w_strb.pc_en;
  assign ctrl.MDR_enable       = w_strb.mdr_en;
  assign ctrl.IR_enable        = w_strb.ir_en;
  assign ctrl.Y_enable         = w_strb.y_en;
  assign ctrl.Z_enable         = w_strb.z_en;
  assign ctrl.IncPC            = w_strb.inc_pc;
  assign ctrl.Read             = w_strb.read;
  assign ctrl.RAM_write_enable = w_strb.ram_we;
  assign ctrl.Gra              = w_strb.gra;
  assign ctrl.Grb              = w_strb.grb;
  assign ctrl.Grc              = w_strb.grc;
  assign ctrl.R_in             = w_strb.r_in;
  assign ctrl.R_out            = w_strb.r_out;
  assign ctrl.Rins             = w_rins;
  assign ctrl.alu_op           = w_strb.alu_op;
  assign ctrl.step             = r_state;
  assign ctrl.run              = (r_state != STEP_RESET) && (r_state != STEP_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: opcode table, hand-written corner
// sequences, then random traffic against a micro-step queue model.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int LINK_REG    = 15;
  localparam int NUM_REGS    = 16;
  localparam int MEM_WAIT_EN = 1;

  localparam logic [18:0] M_PC_OUT   = 19'h40000;
  localparam logic [18:0] M_ZLOW_OUT = 19'h20000;
  localparam logic [18:0] M_MDR_OUT  = 19'h10000;
  localparam logic [18:0] M_C_OUT    = 19'h08000;
  localparam logic [18:0] M_BA_OUT   = 19'h04000;
  localparam logic [18:0] M_MAR_EN   = 19'h02000;
  localparam logic [18:0] M_PC_EN    = 19'h01000;
  localparam logic [18:0] M_MDR_EN   = 19'h00800;
  localparam logic [18:0] M_IR_EN    = 19'h00400;
  localparam logic [18:0] M_Y_EN     = 19'h00200;
  localparam logic [18:0] M_Z_EN     = 19'h00100;
  localparam logic [18:0] M_INC_PC   = 19'h00080;
  localparam logic [18:0] M_READ     = 19'h00040;
  localparam logic [18:0] M_RAM_WE   = 19'h00020;
  localparam logic [18:0] M_GRA      = 19'h00010;
  localparam logic [18:0] M_GRB      = 19'h00008;
  localparam logic [18:0] M_GRC      = 19'h00004;
  localparam logic [18:0] M_R_IN     = 19'h00002;
  localparam logic [18:0] M_R_OUT    = 19'h00001;

  logic Clock = 1'b0;
  logic clr   = 1'b0;
  always #5 Clock = ~Clock;

  control_sequencer_if #(.NUM_REGS(NUM_REGS)) bus ();

  control_sequencer #(
    .LINK_REG    (LINK_REG),
    .NUM_REGS    (NUM_REGS),
    .MEM_WAIT_EN (MEM_WAIT_EN)
  ) dut (
    .Clock (Clock),
    .clr   (clr),
    .ctrl  (bus)
  );

  logic [18:0] strb;
  assign strb = {bus.PC_out, bus.ZLow_out, bus.MDR_out, bus.C_out, bus.BA_out,
                 bus.MAR_enable, bus.PC_enable, bus.MDR_enable, bus.IR_enable,
                 bus.Y_enable, bus.Z_enable, bus.IncPC, bus.Read, bus.RAM_write_enable,
                 bus.Gra, bus.Grb, bus.Grc, bus.R_in, bus.R_out};

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;

  always @(posedge bus.RAM_write_enable) we_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of expected micro-steps ----------
  typedef struct {
    logic [3:0]  step;
    logic [18:0] strb;
    logic        link;
    logic [4:0]  alu;
    logic        hold;
    logic        sticky;
  } ustep_t;

  ustep_t q[$];

  function automatic ustep_t mk(input logic [3:0] s, input logic [18:0] m, input logic link,
                                input logic [4:0] alu, input logic hold, input logic sticky);
    ustep_t u;
    u.step = s; u.strb = m; u.link = link; u.alu = alu; u.hold = hold; u.sticky = sticky;
    return u;
  endfunction

  task automatic push_fetch();
    q.push_back(mk(4'd0, M_PC_OUT | M_MAR_EN | M_INC_PC | M_Z_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
    q.push_back(mk(4'd1, M_ZLOW_OUT | M_PC_EN | M_READ | M_MDR_EN, 1'b0, OP_ADD, 1'b1, 1'b0));
    q.push_back(mk(4'd2, M_MDR_OUT | M_IR_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
  endtask

  task automatic push_exec(input logic [4:0] op);
    case (op)
      OP_JAL: begin
        q.push_back(mk(4'd3, M_PC_OUT, 1'b1, OP_ADD, 1'b0, 1'b0));
        q.push_back(mk(4'd4, M_GRA | M_R_OUT | M_PC_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
      end
      OP_JR: q.push_back(mk(4'd3, M_GRA | M_R_OUT | M_PC_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
      OP_LD, OP_ST: begin
        q.push_back(mk(4'd3, M_GRB | M_BA_OUT | M_Y_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
        q.push_back(mk(4'd4, M_C_OUT | M_Z_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
        q.push_back(mk(4'd5, M_ZLOW_OUT | M_MAR_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
        if (op == OP_LD) begin
          q.push_back(mk(4'd6, M_READ | M_MDR_EN, 1'b0, OP_ADD, 1'b1, 1'b0));
          q.push_back(mk(4'd7, M_MDR_OUT | M_GRA | M_R_IN, 1'b0, OP_ADD, 1'b0, 1'b0));
        end else begin
          q.push_back(mk(4'd6, M_GRA | M_R_OUT | M_MDR_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
          q.push_back(mk(4'd7, M_RAM_WE, 1'b0, OP_ADD, 1'b0, 1'b0));
        end
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
        q.push_back(mk(4'd3, M_GRB | M_R_OUT | M_Y_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
        if (op == OP_ADDI)
          q.push_back(mk(4'd4, M_C_OUT | M_Z_EN, 1'b0, OP_ADD, 1'b0, 1'b0));
        else
          q.push_back(mk(4'd4, M_GRC | M_R_OUT | M_Z_EN, 1'b0, op, 1'b0, 1'b0));
        q.push_back(mk(4'd5, M_ZLOW_OUT | M_GRA | M_R_IN, 1'b0, OP_ADD, 1'b0, 1'b0));
      end
      OP_HALT: begin
        q.push_back(mk(4'd3, '0, 1'b0, OP_ADD, 1'b0, 1'b0));
        q.push_back(mk(4'd9, '0, 1'b0, OP_ADD, 1'b0, 1'b1));
      end
      default: q.push_back(mk(4'd3, '0, 1'b0, OP_ADD, 1'b0, 1'b0));
    endcase
  endtask

  task automatic model_reset();
    q.delete();
    q.push_back(mk(4'd8, '0, 1'b0, OP_ADD, 1'b0, 1'b0));
  endtask

  task automatic model_edge(input logic mr, input logic [4:0] opc);
    ustep_t f;
    f = q[0];
    if (f.sticky) return;
    if (f.hold && (MEM_WAIT_EN != 0) && !mr) return;
    void'(q.pop_front());
    if (f.step == 4'd2) push_exec(opc);
    if (q.size() == 0) push_fetch();
  endtask

  // ---------------- helpers --------------------------------------------------
  task automatic wait_step(input logic [3:0] s);
    int n = 0;
    while (bus.step != s && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (bus.step != s) check($sformatf("wait_step_%0d", s), 64'(bus.step), 64'(s));
  endtask

  task automatic run_instr(input logic [4:0] op, output int len, output logic [18:0] t3,
                           output logic [15:0] t3_rins, output logic [4:0] t4_alu);
    len = 1; t3 = '0; t3_rins = '0; t4_alu = OP_ADD;
    bus.ir_opcode = op;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (bus.step == 4'd0 || bus.step == 4'd9) break;
      len++;
      if (bus.step == 4'd3) begin
        t3 = strb;
        t3_rins = bus.Rins;
        bus.ir_opcode = OP_HALT;
      end
      if (bus.step == 4'd4) t4_alu = bus.alu_op;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    int          len;
    logic [18:0] t3;
    logic        link;
    logic        chk_alu;
    logic [4:0]  alu;
  } vec_t;

  vec_t        tbl[12];
  logic [4:0]  ops_list[11];
  ustep_t      e;
  int          len;
  logic [18:0] t3;
  logic [15:0] t3_rins;
  logic [4:0]  t4_alu;
  int          halt_cnt;
  int          idx;
  logic [44:0] act_v;
  logic [44:0] exp_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_LD,    8, M_GRB | M_BA_OUT | M_Y_EN, 1'b0, 1'b0, OP_ADD};
    tbl[1]  = '{OP_ST,    8, M_GRB | M_BA_OUT | M_Y_EN, 1'b0, 1'b0, OP_ADD};
    tbl[2]  = '{OP_ADD,   6, M_GRB | M_R_OUT | M_Y_EN,  1'b0, 1'b1, OP_ADD};
    tbl[3]  = '{OP_SUB,   6, M_GRB | M_R_OUT | M_Y_EN,  1'b0, 1'b1, OP_SUB};
    tbl[4]  = '{OP_AND,   6, M_GRB | M_R_OUT | M_Y_EN,  1'b0, 1'b1, OP_AND};
    tbl[5]  = '{OP_OR,    6, M_GRB | M_R_OUT | M_Y_EN,  1'b0, 1'b1, OP_OR};
    tbl[6]  = '{OP_ADDI,  6, M_GRB | M_R_OUT | M_Y_EN,  1'b0, 1'b1, OP_ADD};
    tbl[7]  = '{OP_JR,    4, M_GRA | M_R_OUT | M_PC_EN, 1'b0, 1'b0, OP_ADD};
    tbl[8]  = '{OP_JAL,   5, M_PC_OUT,                  1'b1, 1'b0, OP_ADD};
    tbl[9]  = '{OP_NOP,   4, 19'h0,                     1'b0, 1'b0, OP_ADD};
    tbl[10] = '{5'b00001, 4, 19'h0,                     1'b0, 1'b0, OP_ADD};
    tbl[11] = '{5'b11111, 4, 19'h0,                     1'b0, 1'b0, OP_ADD};
    ops_list = '{OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                 OP_JR, OP_JAL, OP_NOP, OP_HALT};

    bus.ir_opcode = OP_NOP;
    bus.mem_ready = 1'b1;

    // Reset, then free-run fetch: 8,0,1,2,3
    @(negedge Clock);
    check("reset_step",    64'(bus.step),   64'(8));
    check("reset_strobes", 64'(strb),       64'(0));
    check("reset_rins",    64'(bus.Rins),   64'(0));
    check("reset_alu",     64'(bus.alu_op), 64'(OP_ADD));
    check("reset_run",     64'(bus.run),    64'(0));
    clr = 1'b1;
    @(negedge Clock);
    check("seq_t0_step", 64'(bus.step), 64'(0));
    check("seq_t0_strb", 64'(strb), 64'(M_PC_OUT | M_MAR_EN | M_INC_PC | M_Z_EN));
    check("seq_t0_run",  64'(bus.run), 64'(1));
    @(negedge Clock);
    check("seq_t1_step", 64'(bus.step), 64'(1));
    @(negedge Clock);
    check("seq_t2_step", 64'(bus.step), 64'(2));
    @(negedge Clock);
    check("seq_t3_step", 64'(bus.step), 64'(3));

    // Opcode table: instruction length, T3 strobes, T4 ALU op
    wait_step(4'd0);
    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, len, t3, t3_rins, t4_alu);
      check($sformatf("tbl_len_%05b", tbl[i].op), 64'(len), 64'(tbl[i].len));
      check($sformatf("tbl_t3_%05b", tbl[i].op), 64'(t3), 64'(tbl[i].t3));
      check($sformatf("tbl_rins_%05b", tbl[i].op), 64'(t3_rins),
            tbl[i].link ? (64'(1) << LINK_REG) : 64'(0));
      if (tbl[i].chk_alu)
        check($sformatf("tbl_alu_%05b", tbl[i].op), 64'(t4_alu), 64'(tbl[i].alu));
    end

    // jal detail
    wait_step(4'd0);
    bus.ir_opcode = OP_JAL;
    wait_step(4'd3);
    check("jal_t3_strb", 64'(strb), 64'(M_PC_OUT));
    check("jal_t3_rins", 64'(bus.Rins), 64'(16'h8000));
    @(negedge Clock);
    check("jal_t4_step", 64'(bus.step), 64'(4));
    check("jal_t4_strb", 64'(strb), 64'(M_GRA | M_R_OUT | M_PC_EN));
    @(negedge Clock);
    check("jal_next_step", 64'(bus.step), 64'(0));

    // ld with three not-ready edges in T6
    bus.ir_opcode = OP_LD;
    wait_step(4'd5);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check($sformatf("ld_wait_step_%0d", i), 64'(bus.step), 64'(6));
      check($sformatf("ld_wait_read_%0d", i), 64'(bus.Read), 64'(1));
      if (i == 3) bus.mem_ready = 1'b1;
    end
    @(negedge Clock);
    check("ld_t7_step", 64'(bus.step), 64'(7));
    check("ld_t7_strb", 64'(strb), 64'(M_MDR_OUT | M_GRA | M_R_IN));

    // sub execute detail
    wait_step(4'd0);
    bus.ir_opcode = OP_SUB;
    wait_step(4'd4);
    check("sub_t4_strb", 64'(strb), 64'(M_GRC | M_R_OUT | M_Z_EN));
    check("sub_t4_alu",  64'(bus.alu_op), 64'(OP_SUB));
    @(negedge Clock);
    check("sub_t5_strb", 64'(strb), 64'(M_ZLOW_OUT | M_GRA | M_R_IN));
    check("sub_t5_alu",  64'(bus.alu_op), 64'(OP_ADD));

    // halt holds for 20 cycles, only clr exits
    wait_step(4'd0);
    bus.ir_opcode = OP_HALT;
    wait_step(4'd9);
    bus.ir_opcode = OP_NOP;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt_hold_%0d", i), {40'd0, bus.step, strb, bus.run},
            {40'd0, 4'd9, 19'd0, 1'b0});
      @(negedge Clock);
    end
    clr = 1'b0;
    #1;
    check("halt_clr_step", 64'(bus.step), 64'(8));
    @(negedge Clock);
    check("halt_clr_hold", 64'(bus.step), 64'(8));
    clr = 1'b1;
    @(negedge Clock);
    check("halt_restart", 64'(bus.step), 64'(0));

    // clr mid-T5 of st: everything drops immediately, no write pulse
    bus.ir_opcode = OP_ST;
    wait_step(4'd5);
    we_cnt = 0;
    #2 clr = 1'b0;
    #1;
    check("st_clr_step", 64'(bus.step), 64'(8));
    check("st_clr_strb", 64'(strb), 64'(0));
    check("st_clr_run",  64'(bus.run), 64'(0));
    repeat (3) @(negedge Clock);
    check("st_clr_no_write", 64'(we_cnt), 64'(0));
    check("st_clr_stay", 64'(bus.step), 64'(8));

    // Random traffic against the micro-step model
    model_reset();
    halt_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clock);
      e = q[0];
      act_v = {bus.step, strb, bus.Rins, bus.alu_op, bus.run};
      exp_v = {e.step, e.strb, e.link ? (16'(1) << LINK_REG) : 16'h0, e.alu,
               (e.step < 4'd8)};
      check("rand_cycle", 64'(act_v), 64'(exp_v));
      check("rand_bus_exclusive",
            64'($countones({strb[18:14], strb[0]}) <= 1), 64'(1));
      clr = 1'b1;
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      idx = int'($urandom_range(0, 11));
      bus.ir_opcode = (idx == 11) ? 5'($urandom_range(0, 31)) : ops_list[idx];
      if (e.sticky) halt_cnt++;
      if (halt_cnt > 4 || $urandom_range(0, 299) == 0) begin
        clr = 1'b0;
        model_reset();
        halt_cnt = 0;
      end
      @(posedge Clock);
      if (clr) model_edge(bus.mem_ready, bus.ir_opcode);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
